// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the pushbutton conditioning blocks.
package btn_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} btn_state_t;

  // Bits needed for a counter that runs 0 .. limit-1 (never narrower than 1).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both stages clear on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_toggle_pulser.sv
// Debounces a raw pushbutton and emits one-cycle toggle pulses on T, with optional
// auto-repeat while held; the debounced level is exported as btn_level.
module btn_toggle_pulser
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic T,
  output logic btn_level
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RPT_W = cnt_width(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic             btn_s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             t_q, t_d;
  logic             level_q, level_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    t_d     = 1'b0;
    level_d = level_q;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
          rpt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          rpt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          rpt_d   = '0;
          t_d     = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        // Release is checked first so it suppresses a repeat due on the same edge.
        if (!btn_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
          rpt_d   = '0;
        end else if (REPEAT_EN) begin
          if (rpt_q == RPT_LAST) begin
            t_d   = 1'b1;
            rpt_d = RPT_RELOAD;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
          rpt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rpt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rpt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rpt_q   <= '0;
      t_q     <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      t_q     <= t_d;
      level_q <= level_d;
    end
  end

  assign T         = t_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_btn_toggle_pulser.sv
// Bench for btn_toggle_pulser: one instance without and one with auto-repeat, both fed
// the same button stream and checked every cycle against a run-length reference model.
module tb_btn_toggle_pulser;

  localparam int unsigned D      = 4;
  localparam int unsigned DELAY  = 20;
  localparam int unsigned PERIOD = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic t0, l0, t1, l1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic        hist[$];
  logic        prev_s;
  int unsigned run;
  logic        exp_t[2];
  logic        exp_l[2];
  int unsigned age[2];
  bit          rep[2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  btn_toggle_pulser #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_EN       (1'b0),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_PERIOD   (PERIOD)
  ) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .T         (t0),
    .btn_level (l0)
  );

  btn_toggle_pulser #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_PERIOD   (PERIOD)
  ) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .T         (t1),
    .btn_level (l1)
  );

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    prev_s = 1'b0;
    run    = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      exp_t[i] = 1'b0;
      exp_l[i] = 1'b0;
      age[i]   = 0;
    end
  endtask

  // A level change is accepted once the synchronised input has held the new value
  // for D+1 consecutive edges; repeats fire DELAY edges into a hold, then every PERIOD.
  task automatic model_edge(input logic b);
    logic s;
    hist.push_back(b);
    if (hist.size() > 3) hist.delete(0);
    s = (hist.size() == 3) ? hist[0] : 1'b0;
    if (s == prev_s) run++;
    else run = 1;
    prev_s = s;
    for (int unsigned i = 0; i < 2; i++) begin
      exp_t[i] = 1'b0;
      if (!exp_l[i]) begin
        if (s && run == D + 1) begin
          exp_l[i] = 1'b1;
          exp_t[i] = 1'b1;
          age[i]   = 0;
        end
      end else if (!s) begin
        if (run == D + 1) exp_l[i] = 1'b0;
      end else if (run == 1) begin
        age[i] = 0;
      end else begin
        age[i]++;
        if (rep[i] && age[i] >= DELAY && (age[i] - DELAY) % PERIOD == 0)
          exp_t[i] = 1'b1;
      end
    end
  endtask

  // Called at a falling edge: drive, let one rising edge happen, check at the next fall.
  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    check_bit("t_norep", t0, exp_t[0]);
    check_bit("lvl_norep", l0, exp_l[0]);
    check_bit("t_rep", t1, exp_t[1]);
    check_bit("lvl_rep", l1, exp_l[1]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_bit("arst_t0", t0, 1'b0);
    check_bit("arst_l0", l0, 1'b0);
    check_bit("arst_t1", t1, 1'b0);
    check_bit("arst_l1", l1, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic v;
    int unsigned len;
    reset  = 1'b0;
    btn_in = 1'b0;
    model_reset();
    #12;
    check_bit("rst_t0", t0, 1'b0);
    check_bit("rst_l0", l0, 1'b0);
    check_bit("rst_t1", t1, 1'b0);
    check_bit("rst_l1", l1, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Clean press held long enough for several repeats, then release.
    repeat (3) step(1'b0);
    for (int unsigned j = 0; j < 46; j++) begin
      step(1'b1);
      check_bit("press_t0", t0, j == 6);
      check_bit("press_l0", l0, j >= 6);
      check_bit("press_t1", t1, (j == 6) || (j >= 26 && (j - 26) % 8 == 0));
    end
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b0);
      check_bit("rel_l0", l0, i < 6);
      check_bit("rel_t0", t0, 1'b0);
      check_bit("rel_t1", t1, 1'b0);
    end

    // Three-cycle glitch is rejected.
    repeat (3) step(1'b1);
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b0);
      check_bit("glitch_t0", t0, 1'b0);
      check_bit("glitch_l0", l0, 1'b0);
    end

    // Release with bounce: level falls once, six edges after the last fall.
    repeat (10) step(1'b1);
    step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b0);
      check_bit("bounce_l0", l0, i < 6);
      check_bit("bounce_t0", t0, 1'b0);
    end

    // Reset during the second cycle of press debounce restarts the full latency.
    repeat (4) step(1'b1);
    do_reset();
    for (int unsigned j = 0; j < 10; j++) begin
      step(1'b1);
      check_bit("rstpress_t0", t0, j == 6);
      check_bit("rstpress_l0", l0, j >= 6);
    end
    repeat (12) step(1'b0);

    // Random mix of short bounces and long holds, with occasional async resets.
    v = 1'b0;
    for (int unsigned seg = 0; seg < 150; seg++) begin
      v = ~v;
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 7);
      for (int unsigned c = 0; c < len; c++) begin
        step(v);
        if ($urandom_range(0, 299) == 0) do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
